// File: rtl/apb_slave_bridge_if.sv
// apb_slave_bridge_if: APB3/APB4 bus bundle between the SoC fabric (master) and the bridge (slave)
//   paddr/psel/penable/pwrite/pwdata/pstrb : driven by the master
//   prdata/pready/pslverr                  : driven by the slave
interface apb_slave_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;
  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_bridge.sv
// apb_slave_bridge: APB slave front end turning transfers into one-cycle register-bank requests
//   clk, rst_n             : clock, asynchronous active-low reset
//   apb (slave modport)    : APB3/APB4 bus, pready only in the single RESP cycle
//   reg_addr/wdata/wstrb   : backend request fields, held from REQ through RESP
//   reg_write_en/read_en   : one-cycle request strobes
//   reg_rdata/ack/err      : backend response, accepted in REQ or WAIT only
module apb_slave_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_W      = 8,
  parameter int REG_SPACE_BYTES = 256,
  parameter int TIMEOUT_CYCLES  = 16,
  localparam int STRB_W         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_slave_bridge_if.slave     apb,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_W-1:0]     reg_wstrb,
  output logic                  reg_write_en,
  output logic                  reg_read_en,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err
);
  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t                state, state_nx;
  logic                  wr_q, err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  setup, dec_err, timeout, busy;
  assign setup   = apb.psel & ~apb.penable;
  assign dec_err = (apb.paddr >= ADDR_WIDTH'(REG_SPACE_BYTES)) |
                   ((apb.paddr & ADDR_WIDTH'(STRB_W - 1)) != '0);
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign busy    = (state == REQ || state == WAIT) && apb.psel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = setup ? (dec_err ? RESP : REQ) : IDLE;
      REQ:     state_nx = !apb.psel ? IDLE : reg_ack ? RESP : WAIT;
      WAIT:    state_nx = !apb.psel ? IDLE : (reg_ack || timeout) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else if (state == IDLE && setup) begin
      reg_addr  <= apb.paddr[REG_ADDR_W-1:0];
      reg_wdata <= apb.pwdata;
      reg_wstrb <= apb.pwrite ? apb.pstrb : '0;
      wr_q      <= apb.pwrite;
      err_q     <= dec_err;
      rdata_q   <= '0;
    end else if (busy && reg_ack) begin
      rdata_q   <= reg_rdata;
      err_q     <= reg_err;
    end else if (busy && state == WAIT && timeout) begin
      rdata_q   <= '0;
      err_q     <= 1'b1;
    end
  // Loaded while idle so the strobe cycle already counts as 1; the timeout then
  // lands exactly TIMEOUT_CYCLES cycles after the strobe.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)              cnt <= '0;
    else if (state == IDLE)  cnt <= CNT_W'(1);
    else if (cnt != '1)      cnt <= cnt + 1'b1;
  assign apb.pready   = state == RESP;
  assign apb.pslverr  = state == RESP && err_q;
  assign apb.prdata   = (state == RESP && !err_q && !wr_q) ? rdata_q : '0;
  assign reg_write_en = state == REQ && wr_q;
  assign reg_read_en  = state == REQ && !wr_q;
endmodule

// File: tb/tb_apb_slave_bridge.sv
// tb_apb_slave_bridge: randomized self-checking bench for apb_slave_bridge
module tb_apb_slave_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  apb_slave_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb();
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;
  logic        reg_write_en, reg_read_en, reg_ack, reg_err;
  int total = 0;
  int bad = 0;
  apb_slave_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_ADDR_W(8),
    .REG_SPACE_BYTES(256), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      apb.psel = 1'b0;
      apb.penable = 1'b0;
      reg_ack = 1'b0;
    end
  endtask

  // One APB transfer; d = cycles after the strobe at which the backend acks.
  // Expected result is derived from the address map and the latency rules.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input int d, input logic [31:0] rd,
                      input logic re, input string name);
    int exp_cyc, got_cyc, wr_cnt, rd_cnt, leak;
    logic dec, exp_err, got_err;
    logic [31:0] exp_data, got_data, got_wd;
    logic [7:0] got_addr, resp_addr;
    logic [3:0] got_strb;
    dec = addr >= 256 || addr % 4 != 0;
    if (dec) begin
      exp_cyc = 1; exp_err = 1'b1; exp_data = 0;
    end else if (d <= 15) begin
      exp_cyc = d + 2; exp_err = re; exp_data = (wr || re) ? 0 : rd;
    end else begin
      exp_cyc = 17; exp_err = 1'b1; exp_data = 0;
    end
    got_cyc = -1; wr_cnt = 0; rd_cnt = 0; leak = 0;
    got_err = 1'b0; got_data = 0; got_wd = 0; got_addr = 0; got_strb = 0; resp_addr = 0;
    @(negedge clk);
    apb.paddr = addr; apb.psel = 1'b1; apb.penable = 1'b0;
    apb.pwrite = wr; apb.pwdata = wd; apb.pstrb = st; reg_ack = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      wr_cnt += int'(reg_write_en);
      rd_cnt += int'(reg_read_en);
      if (reg_write_en || reg_read_en) begin
        got_addr = reg_addr; got_strb = reg_wstrb; got_wd = reg_wdata;
      end
      if (apb.pready) begin
        got_cyc = k; got_err = apb.pslverr; got_data = apb.prdata; resp_addr = reg_addr;
        break;
      end
      if (apb.prdata !== 0 || apb.pslverr !== 1'b0) leak++;
      apb.penable = 1'b1;
      reg_ack = (k == d + 1);
      reg_err = reg_ack ? re : 1'($urandom);
      reg_rdata = reg_ack ? rd : $urandom;
    end
    reg_ack = 1'b0;
    total++;
    if (got_cyc !== exp_cyc) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", name, got_cyc, exp_cyc);
    end
    total++;
    if (got_err !== exp_err) begin
      bad++; $display("FAIL %s pslverr: got %0b want %0b", name, got_err, exp_err);
    end
    total++;
    if (got_data !== exp_data) begin
      bad++; $display("FAIL %s prdata: got %h want %h", name, got_data, exp_data);
    end
    total++;
    if (wr_cnt !== int'(!dec && wr) || rd_cnt !== int'(!dec && !wr)) begin
      bad++; $display("FAIL %s strobes: got w%0d r%0d want w%0d r%0d", name, wr_cnt, rd_cnt,
                      int'(!dec && wr), int'(!dec && !wr));
    end
    total++;
    if (leak !== 0) begin
      bad++; $display("FAIL %s idle_outputs: got %0d nonzero cycles want 0", name, leak);
    end
    if (!dec) begin
      total++;
      if (got_addr !== addr[7:0] || resp_addr !== addr[7:0]) begin
        bad++; $display("FAIL %s reg_addr: got %h/%h want %h", name, got_addr, resp_addr, addr[7:0]);
      end
      total++;
      if (got_strb !== (wr ? st : 4'h0)) begin
        bad++; $display("FAIL %s reg_wstrb: got %h want %h", name, got_strb, wr ? st : 4'h0);
      end
      if (wr) begin
        total++;
        if (got_wd !== wd) begin
          bad++; $display("FAIL %s reg_wdata: got %h want %h", name, got_wd, wd);
        end
      end
    end
  endtask

  task automatic check_quiet(input int n, input string name);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (apb.pready || reg_write_en || reg_read_en) hits++;
    end
    total++;
    if (hits !== 0) begin
      bad++; $display("FAIL %s quiet: got %0d active cycles want 0", name, hits);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({apb.pready, apb.pslverr, apb.prdata, reg_addr, reg_wdata, reg_wstrb,
         reg_write_en, reg_read_en} !== '0) begin
      bad++;
      $display("FAIL %s outputs: got rdy=%0b err=%0b rd=%h a=%h wd=%h s=%h we=%0b re=%0b want all 0",
               name, apb.pready, apb.pslverr, apb.prdata, reg_addr, reg_wdata, reg_wstrb,
               reg_write_en, reg_read_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    xfer(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "write_ack0");
    idle(1);
    xfer(32'hFC, 1'b1, 32'hA5A5_0001, 4'h5, 2, 32'h0, 1'b0, "write_top");
    idle(1);
  endtask

  task automatic test_read();
    xfer(32'h04, 1'b0, 32'h0, 4'hF, 3, 32'h12345678, 1'b0, "read_ack3");
    idle(1);
  endtask

  task automatic test_decode();
    xfer(32'h100, 1'b0, 32'h0, 4'hF, 0, 32'h1111, 1'b0, "range_err");
    idle(1);
    xfer(32'h02, 1'b1, 32'h55, 4'hF, 0, 32'h0, 1'b0, "align_err");
    idle(1);
  endtask

  task automatic test_timeout();
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 1'b0, "ack_at_limit");
    idle(1);
    xfer(32'h08, 1'b0, 32'h0, 4'h0, 99, 32'hBAD0_BAD0, 1'b0, "timeout");
    repeat (3) begin
      @(negedge clk);
      apb.psel = 1'b0; apb.penable = 1'b0; reg_ack = 1'b1; reg_err = 1'b1;
    end
    reg_ack = 1'b0;
    check_quiet(3, "late_ack");
  endtask

  task automatic test_back_to_back();
    xfer(32'h20, 1'b1, 32'h0BAD_CAFE, 4'h3, 1, 32'h0, 1'b1, "backend_err");
    xfer(32'h24, 1'b0, 32'h0, 4'hF, 0, 32'h7777_1234, 1'b0, "b2b_read");
    idle(1);
  endtask

  task automatic test_abort();
    @(negedge clk);
    apb.paddr = 32'h30; apb.pwrite = 1'b1; apb.pwdata = 32'h1234_ABCD;
    apb.pstrb = 4'hF; apb.psel = 1'b1; apb.penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      apb.penable = 1'b1;
    end
    apb.psel = 1'b0; apb.penable = 1'b0;
    check_quiet(4, "abort");
    xfer(32'h34, 1'b0, 32'h0, 4'h0, 1, 32'h4242_4242, 1'b0, "after_abort");
    @(negedge clk);
    apb.paddr = 32'h38; apb.pwrite = 1'b1; apb.pwdata = 32'hFEED_0001;
    apb.pstrb = 4'hC; apb.psel = 1'b1; apb.penable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      apb.penable = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check_zero("reset_in_wait");
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    rst_n = 1'b1;
    idle(1);
    xfer(32'h3C, 1'b1, 32'h0000_BEEF, 4'h1, 0, 32'h0, 1'b0, "after_reset");
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int d;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(9))
        0:       a = 32'h100 + $urandom_range(255);
        1:       a = {24'h0, 6'($urandom), 2'($urandom_range(3, 1))};
        default: a = {24'h0, 6'($urandom), 2'b00};
      endcase
      d = ($urandom_range(7) == 0) ? $urandom_range(20, 14) : $urandom_range(4);
      xfer(a, 1'($urandom), $urandom, 4'($urandom), d, $urandom,
           ($urandom_range(9) == 0), "random");
      if ($urandom_range(1) == 1) idle($urandom_range(2, 1));
    end
    idle(1);
  endtask

  initial begin
    apb.paddr = 0; apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    apb.pwdata = 0; apb.pstrb = 0;
    reg_rdata = 0; reg_ack = 0; reg_err = 0;
    test_reset();
    test_write();
    test_read();
    test_decode();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
